dcache_wb_buffer: RTL

Write-back buffer between the data cache and `cacheline_adapter`, on the dcache side of the adapter. It absorbs dirty-line evictions so a dcache read miss reaches memory before the writes ahead of it. It also returns buffered lines on read hits, and drains queued writes through the adapter when no read is waiting.

---
 rtl/dcache_wb_buffer_pkg.sv | 20 ++
 rtl/dcache_wb_buffer_tag_cam.sv | 26 ++
 rtl/dcache_wb_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types for the dcache write-back buffer.
// Entry layout and controller states.
package CDB_types;
  localparam int LINE_OFFSET_W = 5;
  localparam int TAG_W = 27;
  localparam int DATA_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    RD_MISS,
    DRAIN
  } wb_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/dcache_wb_buffer_tag_cam.sv
// Tag lookup across all write-back buffer entries.
// Tags are unique, so at most one bit of onehot is set.
module wb_tag_cam
  import CDB_types::*;
#(
  parameter int DEPTH = 2
) (
  input  wb_entry_t                    entries [DEPTH],
  input  logic [TAG_W-1:0]             tag,
  output logic                         hit,
  output logic [DEPTH-1:0]             onehot,
  output logic [$clog2(DEPTH)-1:0]     idx
);
  always_comb begin
    hit = 1'b0;
    onehot = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && entries[i].tag == tag) begin
        hit = 1'b1;
        onehot[i] = 1'b1;
        idx = ($clog2(DEPTH))'(i);
      end
    end
  end
endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between dcache and cacheline adapter.
// Reads bypass queued evictions; idle cycles drain the FIFO.
module dcache_wb_buffer
  import CDB_types::*;
#(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] adp_addr,
  output logic              adp_read,
  output logic              adp_write,
  output logic [LINE_W-1:0] adp_wdata,
  input  logic [LINE_W-1:0] adp_rdata,
  input  logic              adp_resp,
  output logic              wb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_state_t         state;
  wb_entry_t         entries [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [LINE_W-1:0] rdata_q;

  logic              hit;
  logic [DEPTH-1:0]  hit_oh;
  logic [PW-1:0]     hit_idx;
  logic [TAG_W-1:0]  dc_tag;
  logic              full;

  assign dc_tag = dc_addr[ADDR_W-1:LINE_OFFSET_W];
  assign full = (count == CW'(DEPTH));

  wb_tag_cam #(.DEPTH(DEPTH)) u_cam (
    .entries (entries),
    .tag     (dc_tag),
    .hit     (hit),
    .onehot  (hit_oh),
    .idx     (hit_idx)
  );

  // Miss data is passed straight through in the adapter's resp cycle.
  assign dc_resp = (state == ACK) ||
                   (state == RD_MISS && adp_resp);
  assign dc_rdata = (state == RD_MISS && adp_resp) ?
                    adp_rdata : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      rdata_q <= '0;
      adp_addr <= '0;
      adp_read <= 1'b0;
      adp_write <= 1'b0;
      adp_wdata <= '0;
      wb_empty <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (dc_read) begin
            if (hit) begin
              rdata_q <= entries[hit_idx].data;
              state <= ACK;
            end else begin
              adp_read <= 1'b1;
              adp_addr <= dc_addr;
              state <= RD_MISS;
            end
          end else if (dc_write && hit) begin
            for (int i = 0; i < DEPTH; i++)
              if (hit_oh[i]) entries[i].data <= dc_wdata;
            state <= ACK;
          end else if (dc_write && !full) begin
            entries[tail] <= '{valid: 1'b1,
                               tag: dc_tag,
                               data: dc_wdata};
            tail <= tail + 1'b1;
            count <= count + 1'b1;
            wb_empty <= 1'b0;
            state <= ACK;
          end else if (dc_write || count != '0) begin
            adp_write <= 1'b1;
            adp_addr <= {entries[head].tag,
                         {LINE_OFFSET_W{1'b0}}};
            adp_wdata <= entries[head].data;
            state <= DRAIN;
          end
        end
        ACK: begin
          rdata_q <= '0;
          state <= IDLE;
        end
        RD_MISS: begin
          if (adp_resp) begin
            adp_read <= 1'b0;
            adp_addr <= '0;
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (adp_resp) begin
            entries[head].valid <= 1'b0;
            head <= head + 1'b1;
            count <= count - 1'b1;
            wb_empty <= (count == CW'(1));
            adp_write <= 1'b0;
            adp_addr <= '0;
            adp_wdata <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
